itlb_refill_ctrl: RTL and testbench

Miss handler directly downstream of the instruction TLB lookup.
- Accepts one ITLB miss at a time from the fetch-side lookup.
- Requests the translation from the shared second-level TLB (STLB).
- On hit, writes the returned entry into one of the ITLB's 32 slots.
- On STLB miss, raises a TLB-refill fault toward the frontend.
- Victim choice: first invalid slot, otherwise round-robin.

---
 rtl/itlb_refill_ctrl.sv | 154 +++++++++++++++
 tb/tb_itlb_refill_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itlb_refill_ctrl.sv
// ITLB miss handler: fetches a translation from the STLB and fills an ITLB slot,
// or raises a TLB-refill fault when the STLB also misses.
module itlb_refill_ctrl #(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = 5,
    parameter int ENTRY_W = 89
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               miss_valid,
    input  logic [19:0]        miss_vpn,
    input  logic [9:0]         miss_asid,
    output logic               miss_ready,
    input  logic               flush,
    output logic               stlb_req_valid,
    input  logic               stlb_req_ready,
    output logic [19:0]        stlb_req_vpn,
    output logic [9:0]         stlb_req_asid,
    input  logic               stlb_resp_valid,
    input  logic               stlb_resp_hit,
    input  logic [ENTRY_W-1:0] stlb_resp_entry,
    input  logic [ENTRIES-1:0] entry_valid_mask,
    output logic               fill_we,
    output logic [IDX_W-1:0]   fill_idx,
    output logic [ENTRY_W-1:0] fill_entry,
    output logic               refill_done,
    output logic               refill_fault,
    output logic [19:0]        fault_vpn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL,
        S_FAULT,
        S_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [19:0]          vpn_q, vpn_d;
    logic [9:0]           asid_q, asid_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 rst_hold_q, rst_hold_d;

    logic [IDX_W-1:0]     free_idx;
    logic                 free_found;

    // Lowest-numbered invalid slot; free_found=0 means the ITLB is full.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!free_found && !entry_valid_mask[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Registered copy of reset keeps miss_ready low for as long as reset is held.
    assign rst_hold_d = rst_n;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            vpn_q    <= '0;
            asid_q   <= '0;
            entry_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            vpn_q    <= vpn_d;
            asid_q   <= asid_d;
            entry_q  <= entry_d;
            rr_ptr_q <= rr_ptr_d;
        end
        rst_hold_q <= rst_hold_d;
    end

    always_comb begin
        state_d        = state_q;
        vpn_d          = vpn_q;
        asid_d         = asid_q;
        entry_d        = entry_q;
        rr_ptr_d       = rr_ptr_q;

        miss_ready     = 1'b0;
        stlb_req_valid = 1'b0;
        stlb_req_vpn   = vpn_q;
        stlb_req_asid  = asid_q;
        fill_we        = 1'b0;
        fill_idx       = '0;
        fill_entry     = entry_q;
        refill_done    = 1'b0;
        refill_fault   = 1'b0;
        fault_vpn      = vpn_q;

        unique case (state_q)
            S_IDLE: begin
                miss_ready = !rst_hold_q;
                if (!rst_hold_q && miss_valid && !flush) begin
                    vpn_d   = miss_vpn;
                    asid_d  = miss_asid;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                stlb_req_valid = 1'b1;
                if (stlb_req_ready) begin
                    state_d = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (stlb_resp_valid) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else if (stlb_resp_hit) begin
                        entry_d = stlb_resp_entry;
                        state_d = S_FILL;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_FILL: begin
                fill_we     = !flush;
                refill_done = !flush;
                fill_idx    = free_found ? free_idx : rr_ptr_q;
                // Round-robin pointer only advances when it actually chose the victim.
                if (!free_found && !flush) begin
                    rr_ptr_d = (rr_ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            S_FAULT: begin
                refill_fault = !flush;
                state_d      = S_IDLE;
            end
            S_DRAIN: begin
                if (stlb_resp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Bench for itlb_refill_ctrl: scenario tasks drive stimulus and push expected
// fills/faults into queues that a negedge monitor pops and compares.
module tb_itlb_refill_ctrl;

    localparam int ENTRIES = 32;
    localparam int IDX_W   = 5;
    localparam int ENTRY_W = 89;

    logic               clk;
    logic               rst_n;
    logic               miss_valid;
    logic [19:0]        miss_vpn;
    logic [9:0]         miss_asid;
    logic               miss_ready;
    logic               flush;
    logic               stlb_req_valid;
    logic               stlb_req_ready;
    logic [19:0]        stlb_req_vpn;
    logic [9:0]         stlb_req_asid;
    logic               stlb_resp_valid;
    logic               stlb_resp_hit;
    logic [ENTRY_W-1:0] stlb_resp_entry;
    logic [ENTRIES-1:0] entry_valid_mask;
    logic               fill_we;
    logic [IDX_W-1:0]   fill_idx;
    logic [ENTRY_W-1:0] fill_entry;
    logic               refill_done;
    logic               refill_fault;
    logic [19:0]        fault_vpn;

    itlb_refill_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ENTRY_W(ENTRY_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_asid(miss_asid),
        .miss_ready(miss_ready), .flush(flush),
        .stlb_req_valid(stlb_req_valid), .stlb_req_ready(stlb_req_ready),
        .stlb_req_vpn(stlb_req_vpn), .stlb_req_asid(stlb_req_asid),
        .stlb_resp_valid(stlb_resp_valid), .stlb_resp_hit(stlb_resp_hit),
        .stlb_resp_entry(stlb_resp_entry), .entry_valid_mask(entry_valid_mask),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_entry(fill_entry),
        .refill_done(refill_done), .refill_fault(refill_fault), .fault_vpn(fault_vpn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]   idx;
        logic [ENTRY_W-1:0] entry;
    } fill_t;

    fill_t       fill_q[$];
    logic [19:0] fault_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          fills_seen  = 0;
    int          faults_seen = 0;

    // Scoreboard monitor: every fill/fault the DUT produces must match the queue head.
    always @(negedge clk) begin
        if (fill_we === 1'b1) begin
            fill_t exp_f;
            fills_seen++;
            n_checks++;
            if (fill_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_fill: got idx=%0d, none expected", fill_idx);
            end else begin
                exp_f = fill_q.pop_front();
                if (fill_idx !== exp_f.idx || fill_entry !== exp_f.entry || refill_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill: got idx=%0d entry=%h done=%b, want idx=%0d entry=%h done=1",
                             fill_idx, fill_entry, refill_done, exp_f.idx, exp_f.entry);
                end
            end
        end
        if (refill_fault === 1'b1) begin
            logic [19:0] exp_v;
            faults_seen++;
            n_checks++;
            if (fault_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_fault: got vpn=%h, none expected", fault_vpn);
            end else begin
                exp_v = fault_q.pop_front();
                if (fault_vpn !== exp_v || fill_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fault: got vpn=%h fill_we=%b, want vpn=%h fill_we=0",
                             fault_vpn, fill_we, exp_v);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ENTRY_W-1:0] rand_entry();
        return ENTRY_W'({$urandom, $urandom, $urandom});
    endfunction

    // Waits (bounded) for miss_ready, then presents a miss for one cycle; DUT ends in REQ.
    task automatic issue_miss(input logic [19:0] vpn, input logic [9:0] asid, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (miss_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (ok) begin
            miss_valid = 1'b1;
            miss_vpn   = vpn;
            miss_asid  = asid;
            cyc();
            miss_valid = 1'b0;
        end
    endtask

    task automatic send_resp(input logic hit, input logic [ENTRY_W-1:0] entry);
        stlb_resp_valid = 1'b1;
        stlb_resp_hit   = hit;
        stlb_resp_entry = entry;
        cyc();
        stlb_resp_valid = 1'b0;
        stlb_resp_hit   = 1'b0;
    endtask

    task automatic do_refill(input logic [19:0] vpn, input logic [IDX_W-1:0] exp_idx, output bit ok);
        logic [ENTRY_W-1:0] e;
        e = rand_entry();
        issue_miss(vpn, 10'h055, ok);
        if (ok) begin
            cyc();
            fill_q.push_back('{idx: exp_idx, entry: e});
            send_resp(1'b1, e);
            cyc();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if ({miss_ready, stlb_req_valid, fill_we, refill_done, refill_fault} !== 5'b0 ||
            stlb_req_vpn !== 20'h0 || fault_vpn !== 20'h0 || fill_entry !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got ready=%b req=%b we=%b done=%b fault=%b vpn=%h, want all 0",
                     miss_ready, stlb_req_valid, fill_we, refill_done, refill_fault, stlb_req_vpn);
        end
        rst_n = 1'b0;
        cyc();
        n_checks++;
        if (miss_ready !== 1'b1 || {stlb_req_valid, fill_we, refill_done, refill_fault} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b req=%b we=%b done=%b fault=%b, want ready=1 rest 0",
                     miss_ready, stlb_req_valid, fill_we, refill_done, refill_fault);
        end
    endtask

    task automatic test_basic_fill();
        bit ok;
        int f0;
        logic [ENTRY_W-1:0] e;
        f0 = fills_seen;
        e  = rand_entry();
        entry_valid_mask = 32'hFFFF_FFFE;
        stlb_req_ready   = 1'b1;
        issue_miss(20'h12345, 10'h003, ok);
        n_checks++;
        if (!ok || stlb_req_valid !== 1'b1 || stlb_req_vpn !== 20'h12345 || stlb_req_asid !== 10'h003) begin
            n_fail++;
            $display("FAIL basic_req: got ok=%b valid=%b vpn=%h asid=%h, want 1 1 12345 003",
                     ok, stlb_req_valid, stlb_req_vpn, stlb_req_asid);
        end
        cyc();
        cyc();
        fill_q.push_back('{idx: 5'd0, entry: e});
        send_resp(1'b1, e);
        cyc();
        n_checks++;
        if (fills_seen - f0 !== 1 || miss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: got fills=%0d ready=%b, want fills=1 ready=1",
                     fills_seen - f0, miss_ready);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int f0;
        f0 = fills_seen;
        entry_valid_mask = '1;
        for (int i = 0; i < 33; i++) begin
            do_refill(20'h20000 + 20'(i), IDX_W'(i % ENTRIES), ok);
            if (!ok) break;
        end
        n_checks++;
        if (!ok || fills_seen - f0 !== 33) begin
            n_fail++;
            $display("FAIL rr_count: got ok=%b fills=%0d, want ok=1 fills=33", ok, fills_seen - f0);
        end
    endtask

    task automatic test_fault();
        bit ok;
        int g0, f0;
        g0 = faults_seen;
        f0 = fills_seen;
        issue_miss(20'h00ABC, 10'h011, ok);
        cyc();
        fault_q.push_back(20'h00ABC);
        send_resp(1'b0, rand_entry());
        n_checks++;
        if (!ok || refill_fault !== 1'b1 || fill_we !== 1'b0 || fault_vpn !== 20'h00ABC) begin
            n_fail++;
            $display("FAIL fault_pulse: got ok=%b fault=%b we=%b vpn=%h, want 1 1 0 00abc",
                     ok, refill_fault, fill_we, fault_vpn);
        end
        cyc();
        n_checks++;
        if (refill_fault !== 1'b0 || fault_vpn !== 20'h00ABC || faults_seen - g0 !== 1 || fills_seen != f0) begin
            n_fail++;
            $display("FAIL fault_after: got fault=%b vpn=%h faults=%0d fills=%0d, want 0 00abc 1 0",
                     refill_fault, fault_vpn, faults_seen - g0, fills_seen - f0);
        end
    endtask

    task automatic test_flush_wait();
        bit ok;
        int f0;
        f0 = fills_seen;
        issue_miss(20'h0F00D, 10'h001, ok);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (miss_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_ready: cycle %0d got ready=%b, want 0", i, miss_ready);
            end
            cyc();
        end
        send_resp(1'b1, rand_entry());
        n_checks++;
        if (!ok || miss_ready !== 1'b1 || fills_seen != f0) begin
            n_fail++;
            $display("FAIL drain_done: got ok=%b ready=%b fills=%0d, want 1 1 0",
                     ok, miss_ready, fills_seen - f0);
        end
    endtask

    task automatic test_flush_fill();
        bit ok;
        int f0;
        f0 = fills_seen;
        entry_valid_mask = '1;
        issue_miss(20'h0CAFE, 10'h002, ok);
        cyc();
        send_resp(1'b1, rand_entry());
        flush = 1'b1;
        #1;
        n_checks++;
        if (fill_we !== 1'b0 || refill_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_fill: got we=%b done=%b, want 0 0", fill_we, refill_done);
        end
        cyc();
        flush = 1'b0;
        // pointer stayed at 1 because the masked fill did not consume it
        do_refill(20'h0CAFF, 5'd1, ok);
        n_checks++;
        if (!ok || fills_seen - f0 !== 1) begin
            n_fail++;
            $display("FAIL flush_fill_next: got ok=%b fills=%0d, want 1 1", ok, fills_seen - f0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int f0;
        logic [ENTRY_W-1:0] e;
        f0 = fills_seen;
        e  = rand_entry();
        entry_valid_mask = 32'hFFFF_00FF;
        issue_miss(20'h0AAAA, 10'h00A, ok);
        flush = 1'b1;
        cyc();
        flush      = 1'b0;
        miss_valid = 1'b1;
        miss_vpn   = 20'h0BBBB;
        miss_asid  = 10'h00B;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (miss_ready !== 1'b0 || stlb_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_blocked: cycle %0d got ready=%b req=%b, want 0 0",
                         i, miss_ready, stlb_req_valid);
            end
            cyc();
        end
        send_resp(1'b1, rand_entry());
        n_checks++;
        if (miss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got ready=%b, want 1", miss_ready);
        end
        cyc();
        miss_valid = 1'b0;
        n_checks++;
        if (stlb_req_valid !== 1'b1 || stlb_req_vpn !== 20'h0BBBB || stlb_req_asid !== 10'h00B) begin
            n_fail++;
            $display("FAIL b2b_req: got valid=%b vpn=%h asid=%h, want 1 0bbbb 00b",
                     stlb_req_valid, stlb_req_vpn, stlb_req_asid);
        end
        cyc();
        fill_q.push_back('{idx: 5'd8, entry: e});
        send_resp(1'b1, e);
        cyc();
        n_checks++;
        if (!ok || fills_seen - f0 !== 1) begin
            n_fail++;
            $display("FAIL b2b_fill: got ok=%b fills=%0d, want 1 1", ok, fills_seen - f0);
        end
    endtask

    task automatic test_stall_reset();
        bit ok;
        int f0;
        f0 = fills_seen;
        stlb_req_ready = 1'b0;
        issue_miss(20'h0BEEF, 10'h3FF, ok);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (!ok || stlb_req_valid !== 1'b1 || stlb_req_vpn !== 20'h0BEEF || stlb_req_asid !== 10'h3FF) begin
                n_fail++;
                $display("FAIL stall: cycle %0d got valid=%b vpn=%h asid=%h, want 1 0beef 3ff",
                         i, stlb_req_valid, stlb_req_vpn, stlb_req_asid);
            end
            cyc();
        end
        stlb_req_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if ({miss_ready, stlb_req_valid, fill_we, refill_done, refill_fault} !== 5'b0 ||
            stlb_req_vpn !== 20'h0 || fault_vpn !== 20'h0) begin
            n_fail++;
            $display("FAIL midreset: got ready=%b req=%b we=%b done=%b fault=%b vpn=%h, want all 0",
                     miss_ready, stlb_req_valid, fill_we, refill_done, refill_fault, stlb_req_vpn);
        end
        rst_n = 1'b0;
        cyc();
        send_resp(1'b1, rand_entry());
        cyc();
        n_checks++;
        if (miss_ready !== 1'b1 || stlb_req_valid !== 1'b0 || fills_seen != f0) begin
            n_fail++;
            $display("FAIL late_resp: got ready=%b req=%b fills=%0d, want 1 0 0",
                     miss_ready, stlb_req_valid, fills_seen - f0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b1;
        miss_valid       = 1'b0;
        miss_vpn         = '0;
        miss_asid        = '0;
        flush            = 1'b0;
        stlb_req_ready   = 1'b1;
        stlb_resp_valid  = 1'b0;
        stlb_resp_hit    = 1'b0;
        stlb_resp_entry  = '0;
        entry_valid_mask = '1;

        test_reset();
        test_basic_fill();
        test_round_robin();
        test_fault();
        test_flush_wait();
        test_flush_fill();
        test_back_to_back();
        test_stall_reset();
        cyc();

        n_checks++;
        if (fill_q.size() != 0 || fault_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got fills_pending=%0d faults_pending=%0d, want 0 0",
                     fill_q.size(), fault_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
